// File: rtl/fb_arbiter.sv
// Single-port framebuffer arbiter: reserved scanout reads every 4th active pixel,
// remaining cycles shared between an external pixel writer and a clear engine.
module fb_arbiter #(
  parameter int FB_W       = 160,
  parameter int FB_H       = 120,
  parameter int SCALE_LOG2 = 2,
  parameter int AW         = 15,
  parameter int DW         = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [9:0]    sx,
  input  logic [9:0]    sy,
  input  logic          enable,
  input  logic          hsync,
  input  logic          vsync,
  input  logic          wr_valid,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  output logic          wr_ready,
  input  logic          clear_req,
  input  logic [DW-1:0] clear_color,
  output logic          clear_busy,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic [DW-1:0] pix_data,
  output logic          pix_de,
  output logic          hsync_out,
  output logic          vsync_out
);

  typedef enum logic {S_IDLE, S_CLEAR} state_t;

  localparam logic [AW-1:0] LAST_ADDR = AW'(FB_W * FB_H - 1);

  state_t        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] color_q, color_d;
  logic          mem_en_q, mem_en_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic [2:0]    en_pipe_q, en_pipe_d;
  logic [2:0]    hs_pipe_q, hs_pipe_d;
  logic [2:0]    vs_pipe_q, vs_pipe_d;
  logic [1:0]    slot_pipe_q, slot_pipe_d;
  logic [DW-1:0] pix_q, pix_d;

  logic          slot;
  logic [AW-1:0] rd_addr;

  always_comb begin
    slot    = enable && (sx[SCALE_LOG2-1:0] == '0);
    rd_addr = AW'(sy >> SCALE_LOG2) * AW'(FB_W) + AW'(sx >> SCALE_LOG2);
  end

  assign wr_ready = !slot && (state_q == S_IDLE) && !clear_req && !rst;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    color_d     = color_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    // Scanout owns its slot unconditionally; clear and writer only see free cycles.
    if (slot) begin
      mem_en_d   = 1'b1;
      mem_addr_d = rd_addr;
    end else if (state_q == S_CLEAR) begin
      mem_en_d    = 1'b1;
      mem_we_d    = 1'b1;
      mem_addr_d  = cnt_q;
      mem_wdata_d = color_q;
      cnt_d       = cnt_q + 1'b1;
      if (cnt_q == LAST_ADDR) state_d = S_IDLE;
    end else if (wr_valid && wr_ready) begin
      mem_en_d    = 1'b1;
      mem_we_d    = 1'b1;
      mem_addr_d  = wr_addr;
      mem_wdata_d = wr_data;
    end

    if ((state_q == S_IDLE) && clear_req) begin
      state_d = S_CLEAR;
      cnt_d   = '0;
      color_d = clear_color;
    end

    en_pipe_d   = {en_pipe_q[1:0], enable};
    hs_pipe_d   = {hs_pipe_q[1:0], hsync};
    vs_pipe_d   = {vs_pipe_q[1:0], vsync};
    slot_pipe_d = {slot_pipe_q[0], slot};
    // Read data lands two cycles after the slot; hold it for the rest of the group.
    pix_d = en_pipe_q[1] ? (slot_pipe_q[1] ? mem_rdata : pix_q) : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      color_q     <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      en_pipe_q   <= '0;
      hs_pipe_q   <= '1;
      vs_pipe_q   <= '1;
      slot_pipe_q <= '0;
      pix_q       <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      color_q     <= color_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      en_pipe_q   <= en_pipe_d;
      hs_pipe_q   <= hs_pipe_d;
      vs_pipe_q   <= vs_pipe_d;
      slot_pipe_q <= slot_pipe_d;
      pix_q       <= pix_d;
    end
  end

  assign clear_busy = (state_q == S_CLEAR);
  assign mem_en     = mem_en_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign pix_data   = pix_q;
  assign pix_de     = en_pipe_q[2];
  assign hsync_out  = hs_pipe_q[2];
  assign vsync_out  = vs_pipe_q[2];

endmodule
